// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit that owns the architectural HI/LO registers.
// Optional MADD/MADDU/MSUB/MSUBU accumulate ops are enabled by defining MDU_MADD_EN.
module mdu_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  md_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic {IDLE, BUSY} state_t;

  typedef enum logic [3:0] {
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6,
    OP_MADD  = 4'd7,
    OP_MADDU = 4'd8,
    OP_MSUB  = 4'd9,
    OP_MSUBU = 4'd10
  } op_t;

  state_t      state;
  logic [4:0]  cnt;
  logic [31:0] hi_nxt;
  logic [31:0] lo_nxt;
  logic        commit;

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] b_safe;
  logic [31:0] bm_safe;
  logic [31:0] mq;
  logic [31:0] mr;
  logic [31:0] sq;
  logic [31:0] sr;
  logic [31:0] uq;
  logic [31:0] ur;

  logic        accept;
  logic        div_zero;
  logic [4:0]  lat;
  logic [63:0] res;

  assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
  assign prod_u = {32'b0, A} * {32'b0, B};

  // Signed divide is done on magnitudes so 0x80000000 / -1 needs no special case.
  assign a_mag   = A[31] ? (~A + 32'd1) : A;
  assign b_mag   = B[31] ? (~B + 32'd1) : B;
  assign b_safe  = (B == '0) ? 32'd1 : B;
  assign bm_safe = (B == '0) ? 32'd1 : b_mag;
  assign mq      = a_mag / bm_safe;
  assign mr      = a_mag % bm_safe;
  assign sq      = (A[31] ^ B[31]) ? (~mq + 32'd1) : mq;
  assign sr      = A[31] ? (~mr + 32'd1) : mr;
  assign uq      = A / b_safe;
  assign ur      = A % b_safe;

  always_comb begin
    accept   = 1'b0;
    div_zero = 1'b0;
    lat      = 5'(MULT_CYCLES);
    res      = '0;
    case (md_op)
      OP_MULT:  begin accept = 1'b1; res = prod_s; end
      OP_MULTU: begin accept = 1'b1; res = prod_u; end
      OP_DIV: begin
        accept   = 1'b1;
        lat      = 5'(DIV_CYCLES);
        div_zero = (B == '0);
        res      = {sr, sq};
      end
      OP_DIVU: begin
        accept   = 1'b1;
        lat      = 5'(DIV_CYCLES);
        div_zero = (B == '0);
        res      = {ur, uq};
      end
`ifdef MDU_MADD_EN
      OP_MADD:  begin accept = 1'b1; res = {HI, LO} + prod_s; end
      OP_MADDU: begin accept = 1'b1; res = {HI, LO} + prod_u; end
      OP_MSUB:  begin accept = 1'b1; res = {HI, LO} - prod_s; end
      OP_MSUBU: begin accept = 1'b1; res = {HI, LO} - prod_u; end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= '0;
      hi_nxt <= '0;
      lo_nxt <= '0;
      commit <= 1'b0;
      busy   <= 1'b0;
      HI     <= '0;
      LO     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (accept) begin
              hi_nxt <= res[63:32];
              lo_nxt <= res[31:0];
              commit <= ~div_zero;
              cnt    <= lat;
              busy   <= 1'b1;
              state  <= BUSY;
            end else if (md_op == OP_MTHI) begin
              HI <= A;
            end else if (md_op == OP_MTLO) begin
              LO <= A;
            end
          end
        end
        BUSY: begin
          if (cnt == 5'd1) begin
            if (commit) begin
              HI <= hi_nxt;
              LO <= lo_nxt;
            end
            cnt   <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt - 5'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_unit.sv
// Self-checking bench for mdu_unit: directed plan cases plus random ops
// checked against an arithmetic model of HI/LO and busy latency.
module tb_mdu_unit;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk;
  logic        reset;
  logic        start;
  logic [3:0]  md_op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] m_hi;
  logic [31:0] m_lo;

  mdu_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .md_op (md_op),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .HI    (HI),
    .LO    (LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: applies one op to m_hi/m_lo, returns busy latency (0 = none).
  task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int lat);
    longint          sa, sb, q, r;
    longint unsigned p, acc;
    lat = 0;
    sa  = longint'(int'(a));
    sb  = longint'(int'(b));
    case (op)
      4'd1: begin p = longint'(sa * sb); {m_hi, m_lo} = p; lat = MC; end
      4'd2: begin p = {32'b0, a} * {32'b0, b}; {m_hi, m_lo} = p; lat = MC; end
      4'd3: begin
        lat = DC;
        if (b != 0) begin q = sa / sb; r = sa % sb; m_lo = q[31:0]; m_hi = r[31:0]; end
      end
      4'd4: begin
        lat = DC;
        if (b != 0) begin m_lo = a / b; m_hi = a % b; end
      end
      4'd5: m_hi = a;
      4'd6: m_lo = a;
`ifdef MDU_MADD_EN
      4'd7, 4'd8, 4'd9, 4'd10: begin
        acc = {m_hi, m_lo};
        if (op == 4'd7 || op == 4'd9) p = longint'(sa * sb);
        else p = {32'b0, a} * {32'b0, b};
        if (op <= 4'd8) acc = acc + p;
        else acc = acc - p;
        {m_hi, m_lo} = acc;
        lat = MC;
      end
`endif
      default: ;
    endcase
  endtask

  task automatic do_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b);
    int lat;
    int cyc;
    model(op, a, b, lat);
    start = 1'b1; md_op = op; A = a; B = b;
    @(posedge clk); #1;
    start = 1'b0;
    if (lat > 0) begin
      cyc = 0;
      while (busy && cyc < 64) begin @(posedge clk); #1; cyc++; end
      check({tag, "_lat"}, 32'(cyc), 32'(lat));
    end else begin
      check({tag, "_busy"}, {31'b0, busy}, 32'd0);
    end
    check({tag, "_hi"}, HI, m_hi);
    check({tag, "_lo"}, LO, m_lo);
  endtask

  initial begin
    int cyc;
    int lat;
    logic [3:0]  rop;
    logic [31:0] ra, rb;
    reset = 1'b0; start = 1'b0; md_op = '0; A = '0; B = '0;
    m_hi = '0; m_lo = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_hi", HI, 32'd0);
    check("rst_lo", LO, 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Reset asserted on cycle 2 of a MULT: aborts without writing HI/LO.
    start = 1'b1; md_op = 4'd1; A = 32'h1234_5678; B = 32'h0000_0100;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0; #1;
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_hi", HI, 32'd0);
    check("abort_lo", LO, 32'd0);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    do_op("idle", 4'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("idle_hi_c", HI, 32'd0);

    do_op("mult", 4'd1, 32'hFFFF_FFFE, 32'd3);
    check("mult_hi_c", HI, 32'hFFFF_FFFF);
    check("mult_lo_c", LO, 32'hFFFF_FFFA);
    do_op("multu", 4'd2, 32'hFFFF_FFFE, 32'd3);
    check("multu_hi_c", HI, 32'h0000_0002);
    check("multu_lo_c", LO, 32'hFFFF_FFFA);
    do_op("div", 4'd3, 32'hFFFF_FFF9, 32'd2);
    check("div_hi_c", HI, 32'hFFFF_FFFF);
    check("div_lo_c", LO, 32'hFFFF_FFFD);
    do_op("divu", 4'd4, 32'd7, 32'd2);
    check("divu_hi_c", HI, 32'd1);
    check("divu_lo_c", LO, 32'd3);
    do_op("divovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    check("divovf_hi_c", HI, 32'd0);
    check("divovf_lo_c", LO, 32'h8000_0000);

    do_op("mthi", 4'd5, 32'h1234, 32'd0);
    do_op("mtlo", 4'd6, 32'h5678, 32'd0);
    do_op("divu0", 4'd4, 32'd99, 32'd0);
    check("divu0_hi_c", HI, 32'h1234);
    check("divu0_lo_c", LO, 32'h5678);
    do_op("div0", 4'd3, 32'hFFFF_0000, 32'd0);

    // Start on busy cycle 3 of DIVU 9/4 must be ignored.
    model(4'd4, 32'd9, 32'd4, lat);
    start = 1'b1; md_op = 4'd4; A = 32'd9; B = 32'd4;
    @(posedge clk); #1; start = 1'b0;
    cyc = 0;
    while (busy && cyc < 64) begin
      if (cyc == 2) begin start = 1'b1; md_op = 4'd1; A = 32'd2; B = 32'd2; end
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
    end
    check("ign_lat", 32'(cyc), 32'(lat));
    check("ign_hi", HI, 32'd1);
    check("ign_lo", LO, 32'd2);

    do_op("pre_hi", 4'd5, 32'd0, 32'd0);
    do_op("pre_lo", 4'd6, 32'hFFFF_FFFF, 32'd0);
    do_op("maddu", 4'd8, 32'd1, 32'd1);
`ifdef MDU_MADD_EN
    check("maddu_hi_c", HI, 32'd1);
    check("maddu_lo_c", LO, 32'd0);
`else
    check("maddu_hi_c", HI, 32'd0);
    check("maddu_lo_c", LO, 32'hFFFF_FFFF);
`endif

    for (int i = 0; i < 40; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = $urandom;
      rb  = ($urandom_range(0, 7) == 0) ? 32'd0 :
            ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 300)) : $urandom;
      if ($urandom_range(0, 3) == 0) ra = 32'hFFFF_FFFF - 32'($urandom_range(0, 500));
      do_op($sformatf("rnd%0d_op%0d", i, rop), rop, ra, rb);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
